// File: rtl/fetch_stage_pkg.sv
// Shared pipeline types for the RISC-V core: fetch FSM states, the NOP
// encoding and the IF/ID pipeline-register layout.
package riscv_structures;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } if_id_t;

  // An empty IF/ID slot: decode sees a NOP with zeroed PCs.
  function automatic if_id_t if_id_bubble();
    if_id_t b;
    b.valid    = 1'b0;
    b.instr    = NOP_INSTR;
    b.pc       = 32'h0;
    b.pc_plus4 = 32'h0;
    return b;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Signals between the fetch stage and its neighbours: instruction memory,
// hazard unit, execute-stage redirects and the decode-facing IF/ID outputs.
interface fetch_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  modport master (
    output imem_addr, id_valid, id_instr, id_pc, id_pc_plus4, fetch_fault, fetch_count,
    input  imem_rdata, stall, redirect_valid, redirect_target
  );

  modport slave (
    input  imem_addr, id_valid, id_instr, id_pc, id_pc_plus4, fetch_fault, fetch_count,
    output imem_rdata, stall, redirect_valid, redirect_target
  );
endinterface

// File: rtl/fetch_stage_pc_target_check.sv
// Combinational legality check for a fetch address: word aligned and inside
// the instruction memory.
module pc_target_check #(
  parameter int IMEM_WORDS = 256
) (
  input  logic [31:0] addr,
  output logic        legal
);
  // Compare in 33 bits so a memory spanning the full 4 GiB cannot overflow the limit.
  localparam logic [32:0] LIMIT = 33'(IMEM_WORDS) * 33'd4;

  assign legal = (addr[1:0] == 2'b00) && ({1'b0, addr} < LIMIT);
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, captures the instruction into IF/ID,
// and handles stalls, execute redirects and illegal fetch targets.
module fetch_stage
  import riscv_structures::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  fetch_stage_if.master  bus
);

  fetch_state_e state;
  logic [31:0]  pc;
  if_id_t       if_id;
  logic         fault;
  logic [31:0]  count;
  logic         redirect_legal;
  logic         pc_legal;

  pc_target_check #(.IMEM_WORDS(IMEM_WORDS)) u_redirect_check (
    .addr  (bus.redirect_target),
    .legal (redirect_legal)
  );

  pc_target_check #(.IMEM_WORDS(IMEM_WORDS)) u_pc_check (
    .addr  (pc),
    .legal (pc_legal)
  );

  // Redirects outrank the PC check and stalls; a bad target freezes the PC for post-mortem.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= BOOT;
      pc    <= RESET_PC;
      if_id <= if_id_bubble();
      fault <= 1'b0;
      count <= 32'h0;
    end else begin
      case (state)
        BOOT: begin
          if_id <= if_id_bubble();
          state <= RUN;
        end
        RUN: begin
          if (bus.redirect_valid) begin
            if_id <= if_id_bubble();
            if (redirect_legal) begin
              pc <= bus.redirect_target;
            end else begin
              fault <= 1'b1;
              state <= HALT;
            end
          end else if (!pc_legal) begin
            if_id <= if_id_bubble();
            fault <= 1'b1;
            state <= HALT;
          end else if (!bus.stall) begin
            if_id <= '{valid: 1'b1, instr: bus.imem_rdata, pc: pc, pc_plus4: pc + 32'd4};
            pc    <= pc + 32'd4;
            count <= count + 32'd1;
          end
        end
        HALT: begin
          if_id <= if_id_bubble();
          fault <= 1'b1;
        end
        default: begin
          if_id <= if_id_bubble();
          fault <= 1'b1;
          state <= HALT;
        end
      endcase
    end
  end

  assign bus.imem_addr   = pc;
  assign bus.id_valid    = if_id.valid;
  assign bus.id_instr    = if_id.instr;
  assign bus.id_pc       = if_id.pc;
  assign bus.id_pc_plus4 = if_id.pc_plus4;
  assign bus.fetch_fault = fault;
  assign bus.fetch_count = count;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed stimulus queues expected IF/ID
// contents, a negedge monitor compares every cycle that id_valid is high.
module tb_fetch_stage;
  import riscv_structures::*;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t expq[$];

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_WORDS(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Memory image: every word is distinct and never the NOP encoding.
  function automatic logic [31:0] instrAt(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  assign bus.imem_rdata = instrAt(bus.imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic rv, input logic [31:0] tgt);
    bus.stall           = st;
    bus.redirect_valid  = rv;
    bus.redirect_target = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic expectFetch(input logic [31:0] pcv, input logic [31:0] p4);
    exp_t e;
    e.pc       = pcv;
    e.instr    = instrAt(pcv);
    e.pc_plus4 = p4;
    expq.push_back(e);
  endtask

  task automatic checkBubble(input string name);
    checkOutput({name, " id_valid"}, {31'h0, bus.id_valid}, 32'h0);
    checkOutput({name, " id_instr"}, bus.id_instr, 32'h0000_0013);
  endtask

  // Monitor: every cycle decode sees a valid slot must match the next queued entry.
  always @(negedge clk) begin
    if (bus.id_valid === 1'b1) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_valid: got id_pc 0x%08h, expected no valid instruction", bus.id_pc);
      end else begin
        exp_t e;
        e = expq.pop_front();
        checkOutput("id_pc", bus.id_pc, e.pc);
        checkOutput("id_instr", bus.id_instr, e.instr);
        checkOutput("id_pc_plus4", bus.id_pc_plus4, e.pc_plus4);
      end
    end
  end

  initial begin
    checks              = 0;
    failures            = 0;
    rst_n               = 1'b0;
    bus.stall           = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'h0;

    // Reset held for three cycles, with noise on the other inputs.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h0000_0040);
      checkBubble("reset");
      checkOutput("reset fetch_fault", {31'h0, bus.fetch_fault}, 32'h0);
      checkOutput("reset fetch_count", bus.fetch_count, 32'h0);
      checkOutput("reset imem_addr", bus.imem_addr, 32'h0);
    end

    // BOOT cycle ignores the redirect.
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 32'h0000_0080);
    checkBubble("boot");
    checkOutput("boot imem_addr", bus.imem_addr, 32'h0);

    // Sequential fetch of five words.
    expectFetch(32'h00, 32'h04);
    expectFetch(32'h04, 32'h08);
    expectFetch(32'h08, 32'h0C);
    expectFetch(32'h0C, 32'h10);
    expectFetch(32'h10, 32'h14);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("seq fetch_count", bus.fetch_count, 32'd5);

    expectFetch(32'h14, 32'h18);
    applyStimulus(1'b0, 1'b0, 32'h0);

    // Two stall cycles hold IF/ID at 0x14.
    for (int i = 0; i < 2; i++) begin
      expectFetch(32'h14, 32'h18);
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("stall fetch_count", bus.fetch_count, 32'd6);
      checkOutput("stall imem_addr", bus.imem_addr, 32'h18);
    end
    expectFetch(32'h18, 32'h1C);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("resume fetch_count", bus.fetch_count, 32'd7);

    // Redirect beats a simultaneous stall.
    applyStimulus(1'b1, 1'b1, 32'h0000_003C);
    checkBubble("redirect");
    checkOutput("redirect imem_addr", bus.imem_addr, 32'h3C);
    expectFetch(32'h3C, 32'h40);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("redirect fetch_count", bus.fetch_count, 32'd8);

    // Misaligned redirect target faults and halts with the PC frozen.
    applyStimulus(1'b0, 1'b1, 32'h0000_008E);
    checkBubble("bad_redirect");
    checkOutput("bad_redirect fetch_fault", {31'h0, bus.fetch_fault}, 32'h1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(i[0], ~i[0], 32'h0000_0100);
      checkBubble("halt");
      checkOutput("halt fetch_fault", {31'h0, bus.fetch_fault}, 32'h1);
      checkOutput("halt imem_addr", bus.imem_addr, 32'h40);
      checkOutput("halt fetch_count", bus.fetch_count, 32'd8);
    end

    // One-cycle reset pulse out of HALT.
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("rst_halt fetch_fault", {31'h0, bus.fetch_fault}, 32'h0);
    checkOutput("rst_halt fetch_count", bus.fetch_count, 32'h0);
    checkOutput("rst_halt imem_addr", bus.imem_addr, 32'h0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 32'h0000_0100);
    checkBubble("reboot");
    expectFetch(32'h00, 32'h04);
    applyStimulus(1'b0, 1'b0, 32'h0);
    expectFetch(32'h04, 32'h08);
    applyStimulus(1'b0, 1'b0, 32'h0);

    // Run off the end of memory: 0x3F8 and 0x3FC are captured, then fault.
    applyStimulus(1'b0, 1'b1, 32'h0000_03F8);
    checkBubble("end_redirect");
    expectFetch(32'h3F8, 32'h3FC);
    applyStimulus(1'b0, 1'b0, 32'h0);
    expectFetch(32'h3FC, 32'h400);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("edge fetch_fault", {31'h0, bus.fetch_fault}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkBubble("overflow");
    checkOutput("overflow fetch_fault", {31'h0, bus.fetch_fault}, 32'h1);
    checkOutput("overflow imem_addr", bus.imem_addr, 32'h400);
    checkOutput("overflow fetch_count", bus.fetch_count, 32'd4);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkBubble("overflow_halt");

    @(negedge clk);
    checkOutput("scoreboard drained", expq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the RISC-V pipeline. It owns the program counter and drives the word address into the combinational instruction memory. It registers the returned instruction into the IF/ID pipeline register for decode. It also handles hazard-unit stalls, branch/jump redirects from execute, and illegal fetch targets.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- IMEM_WORDS, 256, instruction-memory depth in 32-bit words; fetch addresses at or above IMEM_WORDS*4 are faults.

Ports:
- clk  input  1  pipeline clock; all state updates on posedge.
- rst_n  input  1  reset, synchronous, active-low.
- imem_addr  output  32  byte address to instruction memory; equals the current PC register.
- imem_rdata  input  32  instruction word, combinationally valid in the same cycle as imem_addr.
- stall  input  1  hazard-unit stall; holds PC and IF/ID.
- redirect_valid  input  1  execute stage resolved a taken branch, JAL or JALR.
- redirect_target  input  32  new PC when redirect_valid=1.
- id_valid  output  1  IF/ID register holds a real instruction.
- id_instr  output  32  fetched instruction; 32'h0000_0013 (NOP) whenever id_valid=0.
- id_pc  output  32  PC of id_instr.
- id_pc_plus4  output  32  id_pc+4, used as the JAL/JALR link value.
- fetch_fault  output  1  sticky flag; an illegal fetch target was seen.
- fetch_count  output  32  number of instructions captured into IF/ID, wrapping modulo 2^32.

## Operation
- FSM has three states: BOOT, RUN and HALT.
- On any posedge with rst_n=0, the block loads these reset values:
  - state=BOOT, pc=RESET_PC;
  - id_valid=0, id_instr=NOP, id_pc=0, id_pc_plus4=0;
  - fetch_fault=0, fetch_count=0.
- Reset overrides every other input.
- BOOT lasts exactly one cycle after reset release:
  - imem_addr=RESET_PC;
  - IF/ID stays a bubble and the PC holds;
  - next state is RUN unconditionally, including when stall or redirect_valid is asserted. Redirects in BOOT are ignored.
- RUN resolves inputs in priority order, first match wins:
  - redirect_valid=1 with a legal target: pc<=redirect_target and IF/ID<=bubble. This applies even if stall=1 (redirect beats stall).
  - redirect_valid=1 with an illegal target (target[1:0]!=0 or target>=IMEM_WORDS*4): pc holds, IF/ID<=bubble, fetch_fault<=1, state<=HALT.
  - stall=1: pc and the whole IF/ID register hold; fetch_count holds.
  - Otherwise: IF/ID<={1, imem_rdata, pc, pc+4}, pc<=pc+4 and fetch_count<=fetch_count+1.
- Sequential overflow:
  - In RUN, if pc+4>=IMEM_WORDS*4, the instruction at pc is still captured normally.
  - The next cycle then sees an out-of-range pc, sets fetch_fault and moves to HALT without capturing.
- HALT:
  - IF/ID<=bubble every cycle; pc frozen; inputs ignored; fetch_fault stays 1.
  - Only reset exits HALT.
- The block issues no misaligned memory access: in HALT, imem_addr still shows the frozen pc, which may be out of range, but the data is never captured.
- PC arithmetic is 32-bit unsigned, with wrap modulo 2^32.

## Timing
- Fetch-to-decode latency is one cycle: imem_addr=P in cycle N gives id_pc=P and id_instr=mem[P>>2] in cycle N+1.
- Redirect asserted in cycle N:
  - cycle N+1: id_valid=0 and imem_addr=target;
  - cycle N+2: first valid instruction from target.
  - The one-cycle bubble is the only squash; the execute stage flushes its own younger stages.
- Stall asserted in cycle N: in cycle N+1, IF/ID and imem_addr are unchanged from cycle N.
- Stall and redirect in the same cycle: the redirect is taken and the stall is ignored for that cycle.
- Reset asserted mid-operation: outputs take their reset values at the first posedge with rst_n=0. Any in-flight redirect is discarded.

## Structure
- Shared package riscv_structures: add the fetch_state_e enum (BOOT, RUN, HALT), the NOP_INSTR constant (32'h0000_0013), and the if_id_t packed struct {valid, instr, pc, pc_plus4}.
- IF/ID is a single register of type if_id_t.
- One sub-module is natural: pc_target_check. It is combinational and produces legal = aligned && in-range for a given address and IMEM_WORDS. It is used for both redirect targets and sequential PCs.

## Test plan
- Reset and boot: hold rst_n=0 for 3 cycles, then release. Required:
  - id_valid=0 and id_instr=0x13 during reset and the BOOT cycle;
  - first valid id_pc=0x0 two cycles after release.
- Sequential fetch: run 5 cycles with no stall. Required:
  - id_pc=0,4,8,12,16 in order;
  - id_pc_plus4 = id_pc+4 on every cycle;
  - fetch_count=5.
- Stall: assert stall for 2 cycles while id_pc=0x14. Required: id_pc stays 0x14, instr is unchanged and fetch_count is frozen; then fetch resumes at 0x18.
- Redirect: redirect_valid with target 0x3C in the same cycle as stall=1. Required: next cycle id_valid=0; the cycle after, id_pc=0x3C.
- Faults:
  - redirect to 0x8E: fetch_fault=1, state HALT, id_valid stays 0 for 10 cycles;
  - separately, sequential fetch past 0x3FC with IMEM_WORDS=256 also faults.
- Reset mid-HALT: pulse rst_n=0 for 1 cycle. Required: fetch_fault=0, fetch_count=0, and fetch restarts at RESET_PC.
